// File: rtl/common.sv
// Shared pipeline types: instruction word, canonical NOP, and the fetch buffer entry.
package common;

  typedef logic [31:0] instruction_type;

  localparam instruction_type NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     pc;
    instruction_type instruction;
  } fetch_entry_type;

endpackage

// File: rtl/fetch_buffer.sv
// Power-of-two FIFO of fetch entries with push, pop, synchronous clear and occupancy count.
module fetch_buffer
  import common::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  fetch_entry_type push_data,
  input  logic            pop,
  output fetch_entry_type head,
  output logic [CNT_W-1:0] count,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_type  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full buffer needs for the push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/gnt/rvalid memory handshake, fetch buffer and IF/ID register.
// Optional FETCH_MISALIGN_EN adds a sticky fetch_misaligned flag for unaligned redirects.
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            FetchWrite,
  input  logic            PCSrc,
  input  logic [31:0]     pc_branch,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output instruction_type instruction,
  output logic [31:0]     pc,
  output logic            valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] outstanding, buf_count;
  logic [SUM_W-1:0] in_flight;
  logic             buf_empty, buf_full, pcq_empty, pcq_full;
  logic             grant, resp_keep, bypass, buf_push, buf_pop;
  fetch_entry_type  buf_head, buf_in, pcq_head, pcq_in;
  instruction_type  instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             unused_sig;

  // Addresses of requests granted but not yet answered; its count is the outstanding count.
  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_pc_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .push     (grant),
    .push_data(pcq_in),
    .pop      (imem_rvalid),
    .head     (pcq_head),
    .count    (outstanding),
    .empty    (pcq_empty),
    .full     (pcq_full)
  );

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst      (rst),
    .clr      (PCSrc),
    .push     (buf_push),
    .push_data(buf_in),
    .pop      (buf_pop),
    .head     (buf_head),
    .count    (buf_count),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  assign in_flight = SUM_W'(buf_count) + SUM_W'(outstanding);
  // Capping buffered-plus-outstanding guarantees every response has a buffer slot.
  assign imem_req  = !rst && PCWrite && !PCSrc && (in_flight < SUM_W'(BUF_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign resp_keep = imem_rvalid && (discard_q == '0) && !PCSrc;
  assign bypass    = resp_keep && FetchWrite && buf_empty;
  assign buf_push  = resp_keep && !bypass;
  assign buf_pop   = FetchWrite && !PCSrc && !buf_empty;

  assign pcq_in = '{pc: fetch_pc_q, instruction: NOP_INSTR};
  assign buf_in = '{pc: pcq_head.pc, instruction: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (PCSrc) begin
      fetch_pc_d = {pc_branch[31:2], 2'b00};
      // Everything still in flight after this edge belongs to the wrong path.
      discard_d  = outstanding - CNT_W'(imem_rvalid && (outstanding != '0));
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (PCSrc) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (FetchWrite) begin
      if (!buf_empty) begin
        instr_d = buf_head.instruction;
        pc_d    = buf_head.pc;
        valid_d = 1'b1;
      end else if (bypass) begin
        instr_d = imem_rdata;
        pc_d    = pcq_head.pc;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign valid       = valid_q;

`ifdef FETCH_MISALIGN_EN
  logic misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if (PCSrc && (pc_branch[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign fetch_misaligned = misaligned_q;
`endif

  assign unused_sig = ^{buf_full, pcq_empty, pcq_full, pcq_head.instruction, pc_branch[1:0]};

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a configurable-latency in-order instruction memory.
module tb_fetch_stage;
  import common::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            PCWrite, FetchWrite, PCSrc;
  logic [31:0]     pc_branch;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  instruction_type instruction;
  logic [31:0]     pc;
  logic            valid;
`ifdef FETCH_MISALIGN_EN
  logic            fetch_misaligned;
`endif

  int total = 0;
  int bad = 0;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  int mem_max = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mem_req_t;

  mem_req_t mem_q[$];

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCWrite    (PCWrite),
    .FetchWrite (FetchWrite),
    .PCSrc      (PCSrc),
    .pc_branch  (pc_branch),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .pc         (pc),
    .valid      (valid)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // Memory: a grant in cycle c is answered in cycle c+lat, strictly in order.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
    if (rst) begin
      mem_q.delete();
      mem_max = 0;
    end else begin
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      if (mem_q.size() > mem_max) mem_max = mem_q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at the start of cycle 0, the first cycle out of reset.
  task automatic do_reset(input int unsigned l);
    step();
    rst        = 1'b1;
    PCSrc      = 1'b0;
    FetchWrite = 1'b1;
    PCWrite    = 1'b1;
    imem_gnt   = 1'b1;
    pc_branch  = '0;
    lat        = l;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", valid); end
    total++;
    if (instruction !== NOP_INSTR) begin
      bad++; $display("FAIL reset_instr got=%h want=%h", instruction, NOP_INSTR);
    end
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", pc); end
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", imem_req); end
  endtask

  task automatic test_stream();
    int want [4] = '{-1, -1, 0, 4};
    logic [31:0] ep;
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      @(negedge clk);
      if (c == 0) begin
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
          bad++; $display("FAIL stream_req c=0 got=%0b/%h want=1/0", imem_req, imem_addr);
        end
      end
      total++;
      if (want[c] < 0) begin
        if ({valid, instruction} !== {1'b0, NOP_INSTR}) begin
          bad++; $display("FAIL stream_ifid c=%0d got=%0b/%h want=0/nop", c, valid, instruction);
        end
      end else begin
        ep = 32'(want[c]);
        if ({valid, pc, instruction} !== {1'b1, ep, mem_word(ep)}) begin
          bad++;
          $display("FAIL stream_ifid c=%0d got=%0b/%h/%h want=1/%h/%h", c, valid, pc,
                   instruction, ep, mem_word(ep));
        end
      end
    end
  endtask

  // Continues from test_stream: FetchWrite low during cycles 4..6.
  task automatic test_stall();
    int want [7] = '{8, 8, 8, 8, 12, 16, 20};
    logic [31:0] ep;
    for (int i = 0; i < 7; i++) begin
      step();
      FetchWrite = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      ep = 32'(want[i]);
      total++;
      if ({valid, pc, instruction} !== {1'b1, ep, mem_word(ep)}) begin
        bad++;
        $display("FAIL stall_ifid i=%0d got=%0b/%h/%h want=1/%h/%h", i, valid, pc,
                 instruction, ep, mem_word(ep));
      end
      if (i == 0) begin
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
          bad++; $display("FAIL stall_req i=0 got=%0b/%h want=1/10", imem_req, imem_addr);
        end
      end else if (i < 3) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++; $display("FAIL stall_req i=%0d got=%0b want=0", i, imem_req);
        end
      end
    end
  endtask

  task automatic test_gnt();
    do_reset(1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      imem_gnt = (c < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c < 4) begin
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
          bad++; $display("FAIL gnt_req c=%0d got=%0b/%h want=1/0", c, imem_req, imem_addr);
        end
      end
      total++;
      if (c < 5) begin
        if (valid !== 1'b0) begin bad++; $display("FAIL gnt_valid c=%0d got=%0b want=0", c, valid); end
      end else if ({valid, pc, instruction} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
        bad++; $display("FAIL gnt_ifid c=%0d got=%0b/%h/%h want=1/0/%h", c, valid, pc,
                        instruction, mem_word(32'h0));
      end
    end
  endtask

  // Two-cycle memory; redirect in cycle 4 while the fetch of 8 is still in flight.
  task automatic test_redirect();
    int want [10] = '{-1, -1, -1, 0, 4, -1, -1, -1, 'h100, 'h104};
    logic [31:0] ep;
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      PCSrc     = (c == 4);
      pc_branch = 32'h100;
      @(negedge clk);
      if (c == 4 || c == 5 || c == 6) begin
        ep = (c == 4) ? 32'h0 : ((c == 5) ? 32'h100 : 32'h104);
        total++;
        if (c == 4 ? (imem_req !== 1'b0) : ({imem_req, imem_addr} !== {1'b1, ep})) begin
          bad++; $display("FAIL redirect_req c=%0d got=%0b/%h want=%0b/%h", c, imem_req,
                          imem_addr, c != 4, ep);
        end
      end
      total++;
      if (want[c] < 0) begin
        if ({valid, instruction} !== {1'b0, NOP_INSTR}) begin
          bad++; $display("FAIL redirect_ifid c=%0d got=%0b/%h want=0/nop", c, valid, instruction);
        end
      end else begin
        ep = 32'(want[c]);
        if ({valid, pc, instruction} !== {1'b1, ep, mem_word(ep)}) begin
          bad++;
          $display("FAIL redirect_ifid c=%0d got=%0b/%h/%h want=1/%h/%h", c, valid, pc,
                   instruction, ep, mem_word(ep));
        end
      end
    end
    PCSrc = 1'b0;
  endtask

  task automatic test_redirect_stall();
    int want [9] = '{-1, -1, 0, 4, 8, -1, -1, 'h200, 'h204};
    logic [31:0] ep;
    do_reset(1);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      PCSrc      = (c == 4);
      FetchWrite = (c != 4);
      pc_branch  = 32'h200;
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL rstall_req c=4 got=%0b want=0", imem_req); end
      end
      if (c == 5) begin
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
          bad++; $display("FAIL rstall_req c=5 got=%0b/%h want=1/200", imem_req, imem_addr);
        end
      end
      total++;
      if (want[c] < 0) begin
        if ({valid, instruction} !== {1'b0, NOP_INSTR}) begin
          bad++; $display("FAIL rstall_ifid c=%0d got=%0b/%h want=0/nop", c, valid, instruction);
        end
      end else begin
        ep = 32'(want[c]);
        if ({valid, pc, instruction} !== {1'b1, ep, mem_word(ep)}) begin
          bad++;
          $display("FAIL rstall_ifid c=%0d got=%0b/%h/%h want=1/%h/%h", c, valid, pc,
                   instruction, ep, mem_word(ep));
        end
      end
    end
    PCSrc      = 1'b0;
    FetchWrite = 1'b1;
  endtask

  task automatic test_latency();
    int want [14] = '{-1, -1, -1, -1, 0, 4, -1, -1, 8, 12, -1, -1, 16, 20};
    logic [31:0] ep;
    do_reset(3);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) step();
      @(negedge clk);
      total++;
      if (want[c] < 0) begin
        if ({valid, instruction} !== {1'b0, NOP_INSTR}) begin
          bad++; $display("FAIL latency_ifid c=%0d got=%0b/%h want=0/nop", c, valid, instruction);
        end
      end else begin
        ep = 32'(want[c]);
        if ({valid, pc, instruction} !== {1'b1, ep, mem_word(ep)}) begin
          bad++;
          $display("FAIL latency_ifid c=%0d got=%0b/%h/%h want=1/%h/%h", c, valid, pc,
                   instruction, ep, mem_word(ep));
        end
      end
    end
    total++;
    if (mem_max != 2) begin bad++; $display("FAIL latency_max_outstanding got=%0d want=2", mem_max); end
  endtask

  // Called right after test_latency with requests still in flight.
  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({valid, instruction, pc} !== {1'b0, NOP_INSTR, 32'h0}) begin
      bad++; $display("FAIL async_reset_ifid got=%0b/%h/%h want=0/nop/0", valid, instruction, pc);
    end
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL async_reset_req got=%0b want=0", imem_req); end
  endtask

  task automatic test_misalign();
    do_reset(1);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      PCSrc     = (c == 2);
      pc_branch = 32'h102;
      @(negedge clk);
      if (c == 3) begin
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
          bad++; $display("FAIL misalign_req got=%0b/%h want=1/100", imem_req, imem_addr);
        end
      end
      if (c == 5) begin
        total++;
        if ({valid, pc, instruction} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
          bad++; $display("FAIL misalign_ifid got=%0b/%h/%h want=1/100/%h", valid, pc,
                          instruction, mem_word(32'h100));
        end
      end
`ifdef FETCH_MISALIGN_EN
      total++;
      if (fetch_misaligned !== (c >= 3)) begin
        bad++; $display("FAIL misalign_flag c=%0d got=%0b want=%0b", c, fetch_misaligned, c >= 3);
      end
`endif
    end
    PCSrc = 1'b0;
`ifdef FETCH_MISALIGN_EN
    do_reset(1);
    @(negedge clk);
    total++;
    if (fetch_misaligned !== 1'b0) begin
      bad++; $display("FAIL misalign_flag_after_reset got=%0b want=0", fetch_misaligned);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    PCWrite    = 1'b1;
    FetchWrite = 1'b1;
    PCSrc      = 1'b0;
    pc_branch  = '0;
    imem_gnt   = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_gnt();
    test_redirect();
    test_redirect_stall();
    test_latency();
    test_async_reset();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, issues in-order requests to instruction memory over a request/grant/response handshake, buffers returned words, and drives the IF/ID pipeline register consumed by `decode_stage`. It honours `PCWrite`/`FetchWrite` stalls from the hazard detection unit and redirects on `PCSrc`/`pc_branch` from decode, discarding in-flight wrong-path fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `BUF_DEPTH`, 2, fetch buffer entries; also the cap on buffered-plus-outstanding requests (power of two, ≥2).

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `PCWrite`, in, 1, 0 = issue no new requests and hold fetch PC.
- `FetchWrite`, in, 1, 0 = hold IF/ID register.
- `PCSrc`, in, 1, branch taken in decode; redirect this cycle.
- `pc_branch`, in, 32, redirect target.
- `imem_req`, out, 1, request valid.
- `imem_addr`, out, 32, request address (word aligned).
- `imem_gnt`, in, 1, request accepted this cycle.
- `imem_rvalid`, in, 1, response valid; in order, ≥1 cycle after grant.
- `imem_rdata`, in, 32, response word.
- `instruction`, out, `instruction_type`, IF/ID instruction.
- `pc`, out, 32, IF/ID address of `instruction`.
- `valid`, out, 1, IF/ID holds a real instruction.

## Operation
- State: `fetch_pc`, `outstanding` count, `discard` count, fetch buffer of {pc, word}, IF/ID register.
- Issue: `imem_req` = `PCWrite` & !`PCSrc` & (buffer count + `outstanding`) < `BUF_DEPTH`; `imem_addr` = `fetch_pc`. On req & gnt: `fetch_pc` += 4, `outstanding`++.
- Response: on `imem_rvalid`, `outstanding`--; if `discard`>0 then `discard`-- and drop word; else push {address of oldest outstanding, word}. A pc FIFO of outstanding addresses provides the address; no overflow, guaranteed by issue rule.
- IF/ID load when `FetchWrite`=1: buffer non-empty -> load head, `valid`=1, pop; empty -> `instruction`=NOP (32'h0000_0013), `valid`=0. A response arriving into an empty buffer bypasses into IF/ID the same edge.
- `FetchWrite`=0: IF/ID and buffer hold; responses still accepted into buffer.
- Redirect (`PCSrc`=1, priority over both stalls): `fetch_pc` <= {`pc_branch`[31:2],2'b00}; buffer cleared; `discard` <= `outstanding` minus any response accepted this cycle plus any grant this cycle (none, req is low); IF/ID <= NOP, `valid`=0.
- Counters never underflow; `rvalid` with `outstanding`=0 is a protocol violation (assertion).

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, `outstanding`=`discard`=0, buffer empty, `instruction`=NOP, `pc`=`RESET_PC`, `valid`=0, `imem_req`=0 while `rst` high.
- Zero-wait memory (gnt same cycle, rvalid next): first `valid`=1 two cycles after reset release; sustained 1 instr/cycle.
- Redirect at edge N: request to target in cycle N+1, target instruction `valid` at IF/ID after edge N+2 (2-cycle bubble).
- Reset asserted mid-flight: all state returns to reset values immediately; responses to pre-reset requests must not arrive after release (memory is reset by the same `rst`).

## Configuration
- `FETCH_MISALIGN_EN`: adds output `fetch_misaligned` (1 bit, reset 0), sticky-set when `PCSrc`=1 and `pc_branch`[1:0]≠0; cleared only by `rst`. Without macro: port absent, low bits silently zeroed. Redirect address forced aligned in both cases.

## Structure
- Shared package (`common`): `NOP_INSTR` constant, `fetch_entry_type` struct {pc, instruction_type}; `instruction_type` already lives there.
- Sub-module `fetch_buffer`: parameterised FIFO of `fetch_entry_type` with push, pop, synchronous clear, count, empty/full.

## Test plan
- Reset release, zero-wait memory returning addr-derived words -> IF/ID shows pc 0,4,8,… `valid`=1 from cycle 2, one per cycle.
- `FetchWrite`=0 for 3 cycles at pc 8 -> IF/ID holds pc 8; requests stop once buffer+outstanding=2; pc 12 follows on release.
- `PCSrc`=1, `pc_branch`=0x100, with 1 outstanding -> late response dropped, next `valid` instruction pc 0x100, two bubble cycles.
- Memory with 3-cycle response latency -> never more than 2 outstanding; order preserved; `valid` gaps match latency.
- `PCSrc` and `FetchWrite`=0 same cycle -> redirect wins, IF/ID becomes NOP `valid`=0.
- `pc_branch`=0x102 with `FETCH_MISALIGN_EN` -> fetch at 0x100, `fetch_misaligned`=1 until `rst`.
